// File: rtl/alu_retire_if.sv
// Beat/writeback bundle between the ALU side and the retire stage.
// The retire stage takes the slave view; the producer/checker takes the master view.
interface alu_retire_if #(
    parameter int unsigned CNT_WIDTH = 32
) ();
    logic                 in_Valid;
    logic                 out_Ready;
    logic                 in_Stall;
    logic [31:0]          in_Y;
    logic [3:0]           in_CNZV;
    logic                 in_Writeback;
    logic                 in_Set_cond;
    logic [3:0]           in_Rd;
    logic [3:0]           in_Cond;
    logic [3:0]           out_CNZV;
    logic                 out_Rf_we;
    logic [3:0]           out_Rf_addr;
    logic [31:0]          out_Rf_data;
    logic                 out_Pc_we;
    logic [31:0]          out_Pc_data;
    logic [CNT_WIDTH-1:0] out_Retired;
    logic [CNT_WIDTH-1:0] out_Squashed;

    modport slave (
        input  in_Valid, in_Stall, in_Y, in_CNZV, in_Writeback, in_Set_cond, in_Rd, in_Cond,
        output out_Ready, out_CNZV, out_Rf_we, out_Rf_addr, out_Rf_data,
               out_Pc_we, out_Pc_data, out_Retired, out_Squashed
    );

    modport master (
        output in_Valid, in_Stall, in_Y, in_CNZV, in_Writeback, in_Set_cond, in_Rd, in_Cond,
        input  out_Ready, out_CNZV, out_Rf_we, out_Rf_addr, out_Rf_data,
               out_Pc_we, out_Pc_data, out_Retired, out_Squashed
    );
endinterface

// File: rtl/alu_retire.sv
// Retire/writeback stage: ARM condition check, CPSR flag ownership, register-file write,
// PC redirect and wrong-path squash after a redirect.
module alu_retire #(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic          in_Clk,
    input  logic          in_Reset_n,
    alu_retire_if.slave   bus
);
    localparam int unsigned FC_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    logic [FC_W-1:0]      r_cnt;
    logic [3:0]           r_cnzv;
    logic                 r_rf_we;
    logic [3:0]           r_rf_addr;
    logic [31:0]          r_rf_data;
    logic                 r_pc_we;
    logic [31:0]          r_pc_data;
    logic [CNT_WIDTH-1:0] r_retired;
    logic [CNT_WIDTH-1:0] r_squashed;

    logic w_accept;
    logic w_pass;
    logic w_c, w_n, w_z, w_v;
    logic w_rd_pc;

    assign w_accept = bus.in_Valid & ~bus.in_Stall;
    assign w_rd_pc  = (bus.in_Rd == 4'd15);
    assign w_c      = r_cnzv[3];
    assign w_n      = r_cnzv[2];
    assign w_z      = r_cnzv[1];
    assign w_v      = r_cnzv[0];

    // Condition evaluated against the flags committed before this beat
    always_comb begin
        w_pass = 1'b0;
        case (bus.in_Cond)
            4'h0: w_pass = w_z;
            4'h1: w_pass = ~w_z;
            4'h2: w_pass = w_c;
            4'h3: w_pass = ~w_c;
            4'h4: w_pass = w_n;
            4'h5: w_pass = ~w_n;
            4'h6: w_pass = w_v;
            4'h7: w_pass = ~w_v;
            4'h8: w_pass = w_c & ~w_z;
            4'h9: w_pass = ~w_c | w_z;
            4'hA: w_pass = (w_n == w_v);
            4'hB: w_pass = (w_n != w_v);
            4'hC: w_pass = ~w_z & (w_n == w_v);
            4'hD: w_pass = w_z | (w_n != w_v);
            4'hE: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge in_Clk or negedge in_Reset_n) begin
        if (!in_Reset_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_cnzv     <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
            r_pc_we    <= 1'b0;
            r_pc_data  <= '0;
            r_retired  <= '0;
            r_squashed <= '0;
        end else begin
            r_rf_we <= 1'b0;
            r_pc_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_FLUSH: begin
                        // Wrong-path beat: dropped whatever its condition says
                        r_squashed <= r_squashed + CNT_WIDTH'(1);
                        r_cnt      <= r_cnt - FC_W'(1);
                        if (r_cnt == FC_W'(1)) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        if (w_pass) begin
                            r_retired <= r_retired + CNT_WIDTH'(1);
                            if (bus.in_Writeback && w_rd_pc) begin
                                r_pc_we   <= 1'b1;
                                r_pc_data <= {bus.in_Y[31:2], 2'b00};
                                if (FLUSH_DEPTH > 0) begin
                                    r_state <= ST_FLUSH;
                                    r_cnt   <= FC_W'(FLUSH_DEPTH);
                                end
                            end else if (bus.in_Writeback) begin
                                r_rf_we   <= 1'b1;
                                r_rf_addr <= bus.in_Rd;
                                r_rf_data <= bus.in_Y;
                            end
                            // S with Rd==15 would restore SPSR, which this core lacks
                            if (bus.in_Set_cond && !w_rd_pc) begin
                                r_cnzv <= bus.in_CNZV;
                            end
                        end else begin
                            r_squashed <= r_squashed + CNT_WIDTH'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.out_Ready    = ~bus.in_Stall;
    assign bus.out_CNZV     = r_cnzv;
    assign bus.out_Rf_we    = r_rf_we;
    assign bus.out_Rf_addr  = r_rf_addr;
    assign bus.out_Rf_data  = r_rf_data;
    assign bus.out_Pc_we    = r_pc_we;
    assign bus.out_Pc_data  = r_pc_data;
    assign bus.out_Retired  = r_retired;
    assign bus.out_Squashed = r_squashed;
endmodule

// File: tb/tb_alu_retire.sv
// Scoreboard bench for alu_retire: expected writes are queued at issue, a monitor pops on each strobe.
module tb_alu_retire;
    localparam int unsigned CW = 7;

    typedef struct packed {
        logic        pc;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_retire_if #(.CNT_WIDTH(CW)) bus ();

    alu_retire #(.FLUSH_DEPTH(2), .CNT_WIDTH(CW)) dut (
        .in_Clk     (clk),
        .in_Reset_n (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    wr_t exp_q[$];

    logic [3:0]    m_cnzv  = 4'h0;
    logic [CW-1:0] m_ret   = '0;
    logic [CW-1:0] m_sq    = '0;
    int            m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] cnd, input logic [3:0] f);
        logic c, n, z, v;
        {c, n, z, v} = f;
        case (cnd)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Offer one beat; the bench's expectation is formed when it is accepted
    task automatic send(input logic [3:0] cnd, input logic [3:0] rd, input logic [31:0] y,
                        input logic wb, input logic s, input logic [3:0] f);
        wr_t e;
        bus.in_Valid = 1'b1;
        bus.in_Cond = cnd;
        bus.in_Rd = rd;
        bus.in_Y = y;
        bus.in_Writeback = wb;
        bus.in_Set_cond = s;
        bus.in_CNZV = f;
        @(posedge clk);
        if (!bus.in_Stall) begin
            if (m_flush > 0) begin
                m_sq++;
                m_flush--;
            end else if (cond_ok(cnd, m_cnzv)) begin
                m_ret++;
                if (wb) begin
                    e.pc = (rd == 4'd15);
                    e.addr = rd;
                    e.data = (rd == 4'd15) ? {y[31:2], 2'b00} : y;
                    exp_q.push_back(e);
                    if (rd == 4'd15) m_flush = 2;
                end
                if (s && rd != 4'd15) m_cnzv = f;
            end else begin
                m_sq++;
            end
        end
        #1;
        bus.in_Valid = 1'b0;
    endtask

    // Hold the stage with a valid beat pending; nothing may move
    task automatic stall_cycles(input int n);
        logic [CW-1:0] sq0, rt0;
        sq0 = bus.out_Squashed;
        rt0 = bus.out_Retired;
        bus.in_Stall = 1'b1;
        bus.in_Valid = 1'b1;
        bus.in_Cond = 4'hE;
        bus.in_Rd = 4'd9;
        bus.in_Y = 32'hDEAD_0009;
        bus.in_Writeback = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("stall_ready", 32'(bus.out_Ready), 32'd0);
            check("stall_squashed_hold", 32'(bus.out_Squashed), 32'(sq0));
            check("stall_retired_hold", 32'(bus.out_Retired), 32'(rt0));
        end
        bus.in_Valid = 1'b0;
        bus.in_Stall = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && (bus.out_Rf_we || bus.out_Pc_we)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {bus.out_Pc_we, bus.out_Rf_we, 26'd0, bus.out_Rf_addr}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_pc_we", 32'(bus.out_Pc_we), 32'(e.pc));
                check("wr_rf_we", 32'(bus.out_Rf_we), 32'(!e.pc));
                if (e.pc) begin
                    check("pc_data", bus.out_Pc_data, e.data);
                end else begin
                    check("rf_addr", 32'(bus.out_Rf_addr), 32'(e.addr));
                    check("rf_data", bus.out_Rf_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_Valid = 1'b0;
        bus.in_Stall = 1'b0;
        bus.in_Y = '0;
        bus.in_CNZV = '0;
        bus.in_Writeback = 1'b0;
        bus.in_Set_cond = 1'b0;
        bus.in_Rd = '0;
        bus.in_Cond = '0;
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_cnzv", 32'(bus.out_CNZV), 32'd0);
        check("reset_retired", 32'(bus.out_Retired), 32'd0);
        check("reset_squashed", 32'(bus.out_Squashed), 32'd0);
        check("reset_strobes", {30'd0, bus.out_Rf_we, bus.out_Pc_we}, 32'd0);
        check("reset_ready", 32'(bus.out_Ready), 32'd1);

        // AL write of R3
        send(4'hE, 4'd3, 32'h0000_1234, 1'b1, 1'b0, 4'h0);
        check("t1_retired", 32'(bus.out_Retired), 32'd1);
        check("t1_cnzv", 32'(bus.out_CNZV), 32'd0);

        // SUBS sets Z, EQ passes back-to-back, NE fails
        send(4'hE, 4'd1, 32'h0000_0005, 1'b1, 1'b1, 4'b0010);
        send(4'h0, 4'd2, 32'h0000_0007, 1'b1, 1'b0, 4'h0);
        check("t2_cnzv", 32'(bus.out_CNZV), 32'b0010);
        send(4'h1, 4'd4, 32'h0000_0099, 1'b1, 1'b0, 4'h0);
        check("t2_squashed", 32'(bus.out_Squashed), 32'd1);
        check("t2_retired", 32'(bus.out_Retired), 32'd3);

        // Redirect (S ignored for R15), two squashed, third writes
        send(4'hE, 4'd15, 32'h0000_1003, 1'b1, 1'b1, 4'b1111);
        check("t3_cnzv_kept", 32'(bus.out_CNZV), 32'b0010);
        send(4'hE, 4'd5, 32'h0000_0055, 1'b1, 1'b0, 4'h0);
        send(4'hE, 4'd6, 32'h0000_0066, 1'b1, 1'b0, 4'h0);
        check("t3_squashed", 32'(bus.out_Squashed), 32'd3);
        send(4'hE, 4'd7, 32'h0000_0077, 1'b1, 1'b0, 4'h0);
        check("t3_retired", 32'(bus.out_Retired), 32'd5);

        // Flush with stalls between the wrong-path beats
        send(4'hE, 4'd15, 32'h0000_2000, 1'b1, 1'b0, 4'h0);
        stall_cycles(3);
        send(4'hE, 4'd8, 32'h0000_0088, 1'b1, 1'b0, 4'h0);
        stall_cycles(3);
        send(4'hE, 4'd8, 32'h0000_0089, 1'b1, 1'b0, 4'h0);
        check("t4_squashed", 32'(bus.out_Squashed), 32'd5);
        send(4'hE, 4'd10, 32'h0000_00AA, 1'b1, 1'b0, 4'h0);
        check("t4_retired", 32'(bus.out_Retired), 32'd7);

        // Async reset in the middle of a flush
        send(4'hE, 4'd15, 32'h0000_3000, 1'b1, 1'b0, 4'h0);
        send(4'hE, 4'd11, 32'h0000_00BB, 1'b1, 1'b0, 4'h0);
        check("t5_squashed_pre", 32'(bus.out_Squashed), 32'd6);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_cnzv", 32'(bus.out_CNZV), 32'd0);
        check("t5_rst_retired", 32'(bus.out_Retired), 32'd0);
        check("t5_rst_squashed", 32'(bus.out_Squashed), 32'd0);
        check("t5_rst_pc_data", bus.out_Pc_data, 32'd0);
        check("t5_rst_rf_data", bus.out_Rf_data, 32'd0);
        m_cnzv = 4'h0;
        m_ret = '0;
        m_sq = '0;
        m_flush = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'hE, 4'd12, 32'h0000_00CC, 1'b1, 1'b0, 4'h0);
        check("t5_retired", 32'(bus.out_Retired), 32'd1);

        // Condition sweep; 7-bit counters wrap along the way
        for (int f = 0; f < 16; f++) begin
            send(4'hE, 4'd0, 32'h0, 1'b0, 1'b1, 4'(f));
            check("sweep_cnzv", 32'(bus.out_CNZV), 32'(f));
            for (int c = 0; c < 16; c++) begin
                send(4'(c), 4'(c % 15), 32'hC000_0000 | 32'(f * 16 + c), 1'b1, 1'b0, 4'hF);
            end
            check("sweep_retired", 32'(bus.out_Retired), 32'(m_ret));
            check("sweep_squashed", 32'(bus.out_Squashed), 32'(m_sq));
        end
        // 1 + 16 + 128 passes = 145 -> 17 mod 128; 128 fails -> 0 mod 128
        check("wrap_retired", 32'(bus.out_Retired), 32'd17);
        check("wrap_squashed", 32'(bus.out_Squashed), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
